assoc_cache_control: RTL and testbench

ASSOC_CACHE_CONTROL -- requirements
Module: assoc_cache_control

---
 rtl/assoc_cache_control.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_assoc_cache_control.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_control.sv
// ----------------------------------------------------------------------------
// assoc_cache_control
//
// Control unit for a set-associative, write-back, write-allocate cache. It
// owns the per-line valid/dirty bits and the per-set tree pseudo-LRU state.
// The tag and data arrays live in an external datapath, which this block
// steers through way_sel and the ld_* strobes.
//
// Parameters
//   WAYS         associativity (power of two, 2..8)
//   SET_BITS     index width, SETS = 2**SET_BITS
//   OFFSET_BITS  byte-offset width inside a line
//   ADDR_W       address width; TAG_W = ADDR_W - SET_BITS - OFFSET_BITS
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   mem_address          CPU request address
//   mem_read, mem_write  CPU strobes, held until mem_resp (both high = write)
//   mem_resp             one-cycle CPU completion pulse
//   tag_match            raw per-way tag compare from the datapath
//   victim_tag           stored tag of way way_sel at the current index
//   way_sel              way addressed by the datapath
//   ld_line, ld_tag      load the refilled line / its tag into way way_sel
//   ld_word              merge the CPU store word into way way_sel
//   pmem_address         physical memory address
//   pmem_read/pmem_write physical strobes, held until pmem_resp
//   pmem_resp            physical completion pulse
//   hit_count, miss_count, wb_count  saturating statistics counters
//   dbg_state_o          current controller state (IDLE/WRITEBACK/FILL)
//
// Handshakes: a requester raises a strobe and holds it, with its address,
// stable until the matching completion pulse is seen high at a rising edge;
// the completion pulse is high for exactly that one cycle. This holds for
// both the CPU side (mem_* / mem_resp) and the memory side (pmem_* /
// pmem_resp).
// ----------------------------------------------------------------------------
module assoc_cache_control #(
    parameter int WAYS        = 2,
    parameter int SET_BITS    = 3,
    parameter int OFFSET_BITS = 4,
    parameter int ADDR_W      = 16
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [ADDR_W-1:0]                        mem_address,
    input  logic                                     mem_read,
    input  logic                                     mem_write,
    output logic                                     mem_resp,
    input  logic [WAYS-1:0]                          tag_match,
    input  logic [ADDR_W-SET_BITS-OFFSET_BITS-1:0]   victim_tag,
    output logic [$clog2(WAYS)-1:0]                  way_sel,
    output logic                                     ld_line,
    output logic                                     ld_tag,
    output logic                                     ld_word,
    output logic [ADDR_W-1:0]                        pmem_address,
    output logic                                     pmem_read,
    output logic                                     pmem_write,
    input  logic                                     pmem_resp,
    output logic [15:0]                              hit_count,
    output logic [15:0]                              miss_count,
    output logic [15:0]                              wb_count,
    output logic [1:0]                               dbg_state_o
);

    localparam int SETS  = 2 ** SET_BITS;
    localparam int WB    = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WB-1:0]    victim_q, victim_d;
    logic [15:0]      hit_cnt_q, hit_cnt_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;
    logic [15:0]      wb_cnt_q, wb_cnt_d;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [NODES-1:0] plru_q  [SETS];

    // Only the row at the current index is ever modified in a cycle, so the
    // arrays are updated through one next-row value plus a write enable each.
    logic [WAYS-1:0]  valid_row, valid_row_d;
    logic [WAYS-1:0]  dirty_row, dirty_row_d;
    logic [NODES-1:0] plru_row, plru_row_d;
    logic             valid_we, dirty_we, plru_we;

    // ------------------------------------------------------------------
    // Tree pseudo-LRU helpers
    //
    // Nodes are stored heap-style: node 0 is the root, node n has children
    // 2n+1 (bit = 0) and 2n+2 (bit = 1). The node at depth l decides way
    // bit l, least significant bit at the root. A node value names the
    // subtree to evict from next. Bits are extracted by shifting so that a
    // run-time node number never needs to be narrowed to an index width.
    // ------------------------------------------------------------------
    function automatic logic [WB-1:0] plru_victim(input logic [NODES-1:0] tree);
        logic [WB-1:0]    w;
        logic [NODES-1:0] sh;
        int               node;
        w    = '0;
        node = 0;
        for (int l = 0; l < WB; l++) begin
            sh   = tree >> node;
            w    = w | (WB'(sh[0]) << l);
            node = 2 * node + 1 + int'(sh[0]);
        end
        return w;
    endfunction

    // Every node on the accessed way's path is turned to point away from it.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] tree,
                                                    input logic [WB-1:0]    way);
        logic [NODES-1:0] t;
        logic [NODES-1:0] node_mask;
        logic [WB-1:0]    sh;
        logic             dir;
        int               node;
        t    = tree;
        node = 0;
        for (int l = 0; l < WB; l++) begin
            sh        = way >> l;
            dir       = sh[0];
            node_mask = NODES'(1) << node;
            if (dir) t = t & ~node_mask;
            else     t = t | node_mask;
            node = 2 * node + 1 + int'(dir);
        end
        return t;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ------------------------------------------------------------------
    // Lookup at the current index
    // ------------------------------------------------------------------
    logic [SET_BITS-1:0] index;
    logic                req, is_write;
    logic [WAYS-1:0]     hit_vec;
    logic                hit;
    logic [WB-1:0]       hit_way;
    logic                has_invalid;
    logic [WB-1:0]       invalid_way;
    logic [WB-1:0]       miss_victim;
    logic [WAYS-1:0]     hit_oh, victim_oh;

    assign index     = mem_address[OFFSET_BITS +: SET_BITS];
    assign req       = mem_read | mem_write;
    // A simultaneous read and write is handled as a write.
    assign is_write  = mem_write;

    assign valid_row = valid_q[index];
    assign dirty_row = dirty_q[index];
    assign plru_row  = plru_q[index];

    // The datapath compares tags without knowing validity; qualify here.
    assign hit_vec   = tag_match & valid_row;
    assign hit       = |hit_vec;

    // Lowest-numbered matching way and lowest-numbered empty way.
    always_comb begin
        hit_way     = '0;
        invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])    hit_way     = WB'(w);
            if (!valid_row[w]) invalid_way = WB'(w);
        end
    end

    assign has_invalid = ~&valid_row;
    // Empty ways are filled before anything is evicted.
    assign miss_victim = has_invalid ? invalid_way : plru_victim(plru_row);

    assign hit_oh    = WAYS'(1) << hit_way;
    assign victim_oh = WAYS'(1) << victim_q;

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        wb_cnt_d     = wb_cnt_q;

        valid_we     = 1'b0;
        valid_row_d  = valid_row;
        dirty_we     = 1'b0;
        dirty_row_d  = dirty_row;
        plru_we      = 1'b0;
        plru_row_d   = plru_row;

        mem_resp     = 1'b0;
        way_sel      = '0;
        ld_line      = 1'b0;
        ld_tag       = 1'b0;
        ld_word      = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = mem_address;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp   = 1'b1;
                        way_sel    = hit_way;
                        plru_we    = 1'b1;
                        plru_row_d = plru_touch(plru_row, hit_way);
                        hit_cnt_d  = sat_inc(hit_cnt_q);
                        if (is_write) begin
                            ld_word     = 1'b1;
                            dirty_we    = 1'b1;
                            dirty_row_d = dirty_row | hit_oh;
                        end
                    end else begin
                        // The victim is frozen here so the whole miss works on
                        // one way even if the PLRU row or valid bits change.
                        victim_d   = miss_victim;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        if (valid_row[miss_victim] && dirty_row[miss_victim]) begin
                            state_d = ST_WRITEBACK;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end
            end

            ST_WRITEBACK: begin
                way_sel      = victim_q;
                pmem_write   = 1'b1;
                pmem_address = {victim_tag, index, {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    dirty_we    = 1'b1;
                    dirty_row_d = dirty_row & ~victim_oh;
                    wb_cnt_d    = sat_inc(wb_cnt_q);
                    state_d     = ST_FILL;
                end
            end

            ST_FILL: begin
                way_sel      = victim_q;
                pmem_read    = 1'b1;
                pmem_address = {mem_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    ld_line     = 1'b1;
                    ld_tag      = 1'b1;
                    valid_we    = 1'b1;
                    valid_row_d = valid_row | victim_oh;
                    dirty_we    = 1'b1;
                    dirty_row_d = dirty_row & ~victim_oh;
                    // Back to IDLE: a still-pending request now hits there.
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            victim_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
            if (valid_we) valid_q[index] <= valid_row_d;
            if (dirty_we) dirty_q[index] <= dirty_row_d;
            if (plru_we)  plru_q[index]  <= plru_row_d;
        end
    end

    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;
    assign wb_count    = wb_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_assoc_cache_control.sv
// Bench for assoc_cache_control, built with WAYS=4, 8 sets, 16-byte lines,
// 16-bit addresses (tag = addr[15:7], index = addr[6:4]).
// A small tag-array model stands in for the datapath. Expected memory
// transactions ({write, address}) and CPU responses ({ld_word, way}) are
// queued before each request and popped as the DUT produces them.
module tb_assoc_cache_control;

  logic        clk;
  logic        reset_n;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  logic [3:0]  tag_match;
  logic [8:0]  victim_tag;
  logic [1:0]  way_sel;
  logic        ld_line;
  logic        ld_tag;
  logic        ld_word;
  logic [15:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_resp;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] wb_count;
  logic [1:0]  dbg_state;

  assoc_cache_control #(
    .WAYS        (4),
    .SET_BITS    (3),
    .OFFSET_BITS (4),
    .ADDR_W      (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .tag_match    (tag_match),
    .victim_tag   (victim_tag),
    .way_sel      (way_sel),
    .ld_line      (ld_line),
    .ld_tag       (ld_tag),
    .ld_word      (ld_word),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .wb_count     (wb_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath tag model ----------------
  logic [8:0] tag_mem [8][4] = '{default: '0};
  logic [2:0] cur_set;
  logic [8:0] cur_tag;

  assign cur_set = mem_address[6:4];
  assign cur_tag = mem_address[15:7];

  always_comb begin
    for (int w = 0; w < 4; w++) tag_match[w] = (tag_mem[cur_set][w] == cur_tag);
  end
  assign victim_tag = tag_mem[cur_set][way_sel];

  always @(posedge clk) begin
    if (ld_tag) tag_mem[cur_set][way_sel] <= cur_tag;
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];   // {pmem_write, pmem_address}
  logic [2:0]  rsp_q[$];   // {ld_word, way_sel}
  int n_checks = 0;
  int n_pass   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;
  int exp_wb   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_hit_count"},  32'(hit_count),  32'(exp_hit));
    check({tag, "_miss_count"}, 32'(miss_count), 32'(exp_miss));
    check({tag, "_wb_count"},   32'(wb_count),   32'(exp_wb));
  endtask

  task automatic expect_pm(input logic wr, input logic [15:0] addr);
    exp_q.push_back({wr, addr});
  endtask

  task automatic expect_rsp(input logic ldw, input logic [1:0] way);
    rsp_q.push_back({ldw, way});
  endtask

  function automatic logic [15:0] mk_addr(input logic [8:0] tag, input logic [2:0] set);
    return {tag, set, 4'h0};
  endfunction

  // ---------------- driver ----------------
  // Called right after a falling edge. Holds the request until mem_resp,
  // answers memory strobes after 0..3 wait cycles. With drop=1 the request
  // is withdrawn once memory traffic starts; the miss must finish silently.
  task automatic send_req(input logic [15:0] addr, input logic rd, input logic wr,
                          input bit drop, output int cycles);
    int          lat;
    int          quiet;
    bit          in_pm;
    bit          done;
    bit          fill_done;
    logic [16:0] pm_exp;
    logic [2:0]  rs_exp;
    mem_address = addr;
    mem_read    = rd;
    mem_write   = wr;
    pmem_resp   = 1'b0;
    lat = 0; quiet = 0; in_pm = 0; done = 0; fill_done = 0; cycles = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      check("pmem_rd_wr_excl", 32'(pmem_read & pmem_write), 32'd0);
      check("resp_only_idle", 32'(mem_resp & (dbg_state != 2'd0)), 32'd0);
      if (fill_done && (mem_read || mem_write)) check("resp_after_fill", 32'(mem_resp), 32'd1);
      fill_done = 0;
      if (mem_resp) begin
        if (rsp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          rs_exp = rsp_q.pop_front();
          check("resp_way", 32'(way_sel), 32'(rs_exp[1:0]));
          check("resp_ld_word", 32'(ld_word), 32'(rs_exp[2]));
        end
        done = 1;
      end
      if (pmem_resp) begin
        if (pmem_read) begin
          check("fill_ld_line", 32'(ld_line), 32'd1);
          check("fill_ld_tag", 32'(ld_tag), 32'd1);
          fill_done = 1;
          if (!(mem_read || mem_write)) quiet = 3;
        end
        in_pm = 0;
      end else if (pmem_read || pmem_write) begin
        if (!in_pm) begin
          if (exp_q.size() == 0) begin
            check("pm_unexpected", 32'd1, 32'd0);
          end else begin
            pm_exp = exp_q.pop_front();
            check("pm_kind", 32'(pmem_write), 32'(pm_exp[16]));
            check("pm_addr", 32'(pmem_address), 32'(pm_exp[15:0]));
          end
          in_pm = 1;
          lat   = $urandom_range(0, 3);
        end
        if (pmem_read) check("fill_ld_idle", 32'({ld_line, ld_tag}), 32'd0);
      end else if (quiet > 0) begin
        check("dropped_no_resp", 32'(mem_resp), 32'd0);
        quiet--;
        if (quiet == 0) done = 1;
      end
      @(negedge clk);
      if (done) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
      end else begin
        cycles++;
        pmem_resp = in_pm && (lat == 0);
        if (in_pm && lat > 0) lat--;
        if (drop && in_pm) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
      end
    end
    if (!done) check("req_timeout", 32'd0, 32'd1);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          cyc;
    bit          found;
    logic [15:0] a;

    reset_n     = 1'b0;
    mem_address = 16'h1234;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pmem_resp   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_mem_resp", 32'(mem_resp), 32'd0);
    check("rst_pmem_strobes", 32'({pmem_read, pmem_write}), 32'd0);
    check("rst_ld", 32'({ld_line, ld_tag, ld_word}), 32'd0);
    check("rst_pmem_addr", 32'(pmem_address), 32'h1234);
    check_counts("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Cold read: one fill, then a hit on re-evaluation.
    expect_pm(1'b0, 16'h1230); expect_rsp(1'b0, 2'd0);
    send_req(16'h1230, 1'b1, 1'b0, 1'b0, cyc);
    exp_miss++; exp_hit++;
    check_counts("cold_read");

    // Second line in set 3 goes to way 1, then a write hit on it.
    expect_pm(1'b0, 16'h1830); expect_rsp(1'b0, 2'd1);
    send_req(16'h1830, 1'b1, 1'b0, 1'b0, cyc);
    exp_miss++; exp_hit++;
    expect_rsp(1'b1, 2'd1);
    send_req(16'h1830, 1'b0, 1'b1, 1'b0, cyc);
    check("wr_hit_latency", 32'(cyc), 32'd0);
    exp_hit++;
    check_counts("write_hit");

    // Set 2: dirty line tag 0x1A5 in way 0, ways 1..3 clean, then evict.
    expect_pm(1'b0, 16'hD2A0); expect_rsp(1'b1, 2'd0);
    send_req(16'hD2A0, 1'b0, 1'b1, 1'b0, cyc);
    exp_miss++; exp_hit++;
    for (int k = 1; k < 4; k++) begin
      a = mk_addr(9'(9'h010 + k), 3'd2);
      expect_pm(1'b0, a); expect_rsp(1'b0, 2'(k));
      send_req(a, 1'b1, 1'b0, 1'b0, cyc);
      exp_miss++; exp_hit++;
    end
    expect_pm(1'b1, 16'hD2A0); expect_pm(1'b0, 16'h2AA0); expect_rsp(1'b0, 2'd0);
    send_req(16'h2AA0, 1'b1, 1'b0, 1'b0, cyc);
    exp_miss++; exp_hit++; exp_wb++;
    check_counts("dirty_evict");

    // Set 5: fill all four ways, touch 0,1,2, next miss must take way 3.
    for (int k = 0; k < 4; k++) begin
      a = mk_addr(9'(9'h040 + k), 3'd5);
      expect_pm(1'b0, a); expect_rsp(1'b0, 2'(k));
      send_req(a, 1'b1, 1'b0, 1'b0, cyc);
      exp_miss++; exp_hit++;
    end
    for (int k = 0; k < 3; k++) begin
      a = mk_addr(9'(9'h040 + k), 3'd5);
      expect_rsp(1'b0, 2'(k));
      send_req(a, 1'b1, 1'b0, 1'b0, cyc);
      check("plru_touch_latency", 32'(cyc), 32'd0);
      exp_hit++;
    end
    expect_pm(1'b0, 16'h2250); expect_rsp(1'b0, 2'd3);
    send_req(16'h2250, 1'b1, 1'b0, 1'b0, cyc);
    exp_miss++; exp_hit++;
    // After touching way 3 the tree points back at way 0.
    expect_pm(1'b0, 16'h22D0); expect_rsp(1'b0, 2'd0);
    send_req(16'h22D0, 1'b1, 1'b0, 1'b0, cyc);
    exp_miss++; exp_hit++;
    check_counts("plru");

    // Read and write together act as a write (hit on way 2).
    expect_rsp(1'b1, 2'd2);
    send_req(16'h2150, 1'b1, 1'b1, 1'b0, cyc);
    exp_hit++;

    // Request withdrawn during the fill: no response, line still installed.
    expect_pm(1'b0, 16'h3360);
    send_req(16'h3360, 1'b1, 1'b0, 1'b1, cyc);
    exp_miss++;
    expect_rsp(1'b0, 2'd0);
    send_req(16'h3360, 1'b1, 1'b0, 1'b0, cyc);
    check("after_drop_hit_latency", 32'(cyc), 32'd0);
    exp_hit++;
    check_counts("drop");

    // Reset asserted in the middle of a fill.
    mem_address = 16'h3BF0;
    mem_read    = 1'b1;
    found       = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (pmem_read) found = 1;
      else @(negedge clk);
    end
    check("rst_fill_reached", 32'(found), 32'd1);
    check("rst_fill_addr", 32'(pmem_address), 32'h3BF0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_async_state", 32'(dbg_state), 32'd0);
    check("rst_async_pmem_addr", 32'(pmem_address), 32'h3BF0);
    exp_hit = 0; exp_miss = 0; exp_wb = 0;
    check_counts("rst_async");
    mem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Tag array still holds 0x24 in set 3 way 0, but valid was cleared.
    expect_pm(1'b0, 16'h1230); expect_rsp(1'b0, 2'd0);
    send_req(16'h1230, 1'b1, 1'b0, 1'b0, cyc);
    exp_miss++; exp_hit++;
    check_counts("post_rst");

    // Hold a hitting read: one hit per cycle until the counter saturates.
    mem_address = 16'h1230;
    mem_read    = 1'b1;
    repeat (65533) @(negedge clk);
    #1;
    check("sat_hit_fffe", 32'(hit_count), 32'h0000FFFE);
    check("sat_streaming_resp", 32'(mem_resp), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    check("sat_hit_ffff", 32'(hit_count), 32'h0000FFFF);
    check("sat_miss_unchanged", 32'(miss_count), 32'd1);
    mem_read = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
